// File: rtl/iccm_boot_pkg.sv
// Purpose : shared types for the ICCM boot sequencer (FSM states, ICCM write beat).
// Latency : n/a (types and constants only).
// Backpressure : n/a.
package iccm_boot_pkg;

  localparam int ICCM_DATA_W = 32;
  // Widest ICCM word address the write beat can carry.
  localparam int ICCM_ADDR_W = 13;

  typedef enum logic [2:0] {
    HOLD,
    LOAD,
    DRAIN,
    RELEASE,
    RUN
  } boot_state_e;

  typedef struct packed {
    logic [ICCM_ADDR_W-1:0] addr;
    logic [ICCM_DATA_W-1:0] data;
  } iccm_wr_t;

endpackage

// File: rtl/iccm_wr_fifo.sv
// Purpose : synchronous FIFO of ICCM write beats with combinational head output.
// Latency : push -> head visible 1 cycle later; no empty bypass.
// Backpressure : push while full is dropped unless a pop happens in the same cycle.
// Ports : clk_i/csb_rst clock and async active-low reset; push/din write side;
//         pop/head read side; full/empty status.
module iccm_wr_fifo
  import iccm_boot_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     csb_rst,
  input  logic     push,
  input  iccm_wr_t din,
  input  logic     pop,
  output iccm_wr_t head,
  output logic     full,
  output logic     empty
);

  localparam int PW = $clog2(DEPTH);

  // One extra pointer bit tells full from empty when the indices match.
  logic [PW:0] wr_ptr, rd_ptr;
  iccm_wr_t    mem [DEPTH];
  logic        do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop & ~empty;
  // When full, a same-cycle pop frees the slot being written.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk_i or negedge csb_rst) begin
    if (!csb_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/iccm_boot_sequencer.sv
// Purpose : loads loader words into ICCM while holding the core in reset, then hands
//           the ICCM write port to the bus requester.
// Latency : ldr_wvalid_i -> iccm_req_o 1 cycle; RUN-state bus path is combinational.
// Backpressure : iccm_gnt_i stalls the FIFO head; loader pushes into a full FIFO are
//           dropped and flagged in ovf_err_o.
// Ports : ldr_* loader write side; bus_* bus requester; iccm_* ICCM macro port;
//         core_rst_no/boot_done_o/timeout_o/ovf_err_o/word_cnt_o boot status.
module iccm_boot_sequencer
  import iccm_boot_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                    clk_i,
  input  logic                    csb_rst,
  input  logic [ADDR_WIDTH-1:0]   ldr_waddr_i,
  input  logic [ICCM_DATA_W-1:0]  ldr_wdata_i,
  input  logic                    ldr_wvalid_i,
  input  logic                    ldr_done_i,
  input  logic                    bus_req_i,
  input  logic [ADDR_WIDTH-1:0]   bus_addr_i,
  input  logic [ICCM_DATA_W-1:0]  bus_wdata_i,
  output logic                    bus_gnt_o,
  output logic                    iccm_req_o,
  output logic [ADDR_WIDTH-1:0]   iccm_addr_o,
  output logic [ICCM_DATA_W-1:0]  iccm_wdata_o,
  input  logic                    iccm_gnt_i,
  output logic                    core_rst_no,
  output logic                    boot_done_o,
  output logic                    timeout_o,
  output logic                    ovf_err_o,
  output logic [ADDR_WIDTH:0]     word_cnt_o
);

  boot_state_e           state_q, state_d;
  logic                  done_q;
  logic [TIMEOUT_W-1:0]  idle_q;
  logic [ADDR_WIDTH:0]   word_cnt_q;
  logic                  timeout_q, ovf_q, core_rst_q, boot_done_q;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  iccm_wr_t              fifo_din, fifo_head;

  logic                  done_rise, idle_max, to_hit;

  assign done_rise = ldr_done_i & ~done_q;
  assign idle_max  = (idle_q == '1);
  // An idle timeout only ends a load that has written something.
  assign to_hit    = idle_max && (word_cnt_q != '0);

  assign fifo_din.addr = ICCM_ADDR_W'(ldr_waddr_i);
  assign fifo_din.data = ldr_wdata_i;

  iccm_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .csb_rst (csb_rst),
    .push    (fifo_push),
    .din     (fifo_din),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk_i or negedge csb_rst) begin
    if (!csb_rst) state_q <= HOLD;
    else          state_q <= state_d;
  end

  // Next state. The done edge is tested first so it wins over a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HOLD:    state_d = LOAD;
      LOAD:    if (done_rise || to_hit) state_d = DRAIN;
      DRAIN:   if (fifo_empty) state_d = RELEASE;
      RELEASE: state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = HOLD;
    endcase
  end

  // Port ownership: FIFO head during LOAD/DRAIN, bus requester in RUN.
  always_comb begin
    iccm_req_o   = 1'b0;
    iccm_addr_o  = '0;
    iccm_wdata_o = '0;
    bus_gnt_o    = 1'b0;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    unique case (state_q)
      LOAD, DRAIN: begin
        fifo_push = (state_q == LOAD) && ldr_wvalid_i;
        if (!fifo_empty) begin
          iccm_req_o   = 1'b1;
          iccm_addr_o  = ADDR_WIDTH'(fifo_head.addr);
          iccm_wdata_o = fifo_head.data;
          fifo_pop     = iccm_gnt_i;
        end
      end
      RUN: begin
        iccm_req_o   = bus_req_i;
        iccm_addr_o  = bus_addr_i;
        iccm_wdata_o = bus_wdata_i;
        bus_gnt_o    = iccm_gnt_i;
      end
      default: ;
    endcase
  end

  // Status and counters.
  always_ff @(posedge clk_i or negedge csb_rst) begin
    if (!csb_rst) begin
      done_q      <= 1'b0;
      idle_q      <= '0;
      word_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      ovf_q       <= 1'b0;
      core_rst_q  <= 1'b0;
      boot_done_q <= 1'b0;
    end else begin
      done_q <= ldr_done_i;

      if (state_q != LOAD || ldr_wvalid_i) idle_q <= '0;
      else if (!idle_max)                  idle_q <= idle_q + TIMEOUT_W'(1);

      if (fifo_pop && word_cnt_q != '1) word_cnt_q <= word_cnt_q + (ADDR_WIDTH+1)'(1);

      if (state_q == LOAD && !done_rise && to_hit) timeout_q <= 1'b1;

      if (state_q == LOAD && ldr_wvalid_i && fifo_full && !fifo_pop) ovf_q <= 1'b1;

      if (state_q == RELEASE) begin
        core_rst_q  <= 1'b1;
        boot_done_q <= 1'b1;
      end
    end
  end

  assign core_rst_no = core_rst_q;
  assign boot_done_o = boot_done_q;
  assign timeout_o   = timeout_q;
  assign ovf_err_o   = ovf_q;
  assign word_cnt_o  = word_cnt_q;

endmodule

// File: tb/tb_iccm_boot_sequencer.sv
// Purpose : self-checking bench for iccm_boot_sequencer; expected ICCM writes are
//           queued when driven and checked by a negedge monitor on each transfer.
// Latency : n/a.
// Backpressure : iccm_gnt_i is driven per scenario.
module tb_iccm_boot_sequencer;

  localparam int AW = 13;
  localparam int TW = 4;

  logic          clk_i = 1'b0;
  logic          csb_rst = 1'b0;
  logic [AW-1:0] ldr_waddr_i = '0;
  logic [31:0]   ldr_wdata_i = '0;
  logic          ldr_wvalid_i = 1'b0;
  logic          ldr_done_i = 1'b0;
  logic          bus_req_i = 1'b0;
  logic [AW-1:0] bus_addr_i = '0;
  logic [31:0]   bus_wdata_i = '0;
  logic          bus_gnt_o;
  logic          iccm_req_o;
  logic [AW-1:0] iccm_addr_o;
  logic [31:0]   iccm_wdata_o;
  logic          iccm_gnt_i = 1'b0;
  logic          core_rst_no, boot_done_o, timeout_o, ovf_err_o;
  logic [AW:0]   word_cnt_o;

  int tests = 0;
  int fails = 0;
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] mon_exp;
  logic [64:0]    outs;

  assign outs = {iccm_req_o, bus_gnt_o, core_rst_no, boot_done_o, timeout_o, ovf_err_o,
                 word_cnt_o, iccm_addr_o, iccm_wdata_o};

  iccm_boot_sequencer #(.ADDR_WIDTH(AW), .FIFO_DEPTH(4), .TIMEOUT_W(TW)) dut (
    .clk_i        (clk_i),
    .csb_rst      (csb_rst),
    .ldr_waddr_i  (ldr_waddr_i),
    .ldr_wdata_i  (ldr_wdata_i),
    .ldr_wvalid_i (ldr_wvalid_i),
    .ldr_done_i   (ldr_done_i),
    .bus_req_i    (bus_req_i),
    .bus_addr_i   (bus_addr_i),
    .bus_wdata_i  (bus_wdata_i),
    .bus_gnt_o    (bus_gnt_o),
    .iccm_req_o   (iccm_req_o),
    .iccm_addr_o  (iccm_addr_o),
    .iccm_wdata_o (iccm_wdata_o),
    .iccm_gnt_i   (iccm_gnt_i),
    .core_rst_no  (core_rst_no),
    .boot_done_o  (boot_done_o),
    .timeout_o    (timeout_o),
    .ovf_err_o    (ovf_err_o),
    .word_cnt_o   (word_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Every ICCM transfer must match the oldest expected write.
  always @(negedge clk_i) begin
    if (iccm_req_o && iccm_gnt_i) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL iccm_write: unexpected write addr=%h data=%h", iccm_addr_o, iccm_wdata_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({iccm_addr_o, iccm_wdata_o} !== mon_exp) begin
          fails++;
          $display("FAIL iccm_write: got addr=%h data=%h, want addr=%h data=%h",
                   iccm_addr_o, iccm_wdata_o, mon_exp[AW+31:32], mon_exp[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    csb_rst = 1'b0;
    ldr_wvalid_i = 1'b0;
    ldr_done_i = 1'b0;
    bus_req_i = 1'b0;
    iccm_gnt_i = 1'b0;
    exp_q.delete();
    tick();
    tick();
    csb_rst = 1'b1;
  endtask

  task automatic push_word(input logic [AW-1:0] a, input logic [31:0] d, input bit expect_wr);
    ldr_waddr_i  = a;
    ldr_wdata_i  = d;
    ldr_wvalid_i = 1'b1;
    if (expect_wr) exp_q.push_back({a, d});
    tick();
  endtask

  task automatic test_reset();
    csb_rst = 1'b0;
    #1;
    tests++;
    if (outs !== 65'd0) begin fails++; $display("FAIL reset_outputs: got %h want 0", outs); end
    do_reset();
    #1;
    tests++;
    if (outs !== 65'd0) begin fails++; $display("FAIL hold_outputs: got %h want 0", outs); end
    tick();
    bus_req_i = 1'b1;
    bus_addr_i = 13'h0123;
    iccm_gnt_i = 1'b1;
    #1;
    tests++;
    if ({iccm_req_o, bus_gnt_o, core_rst_no} !== 3'b000) begin
      fails++;
      $display("FAIL load_ignores_bus: got req/gnt/rst_n=%b want 000", {iccm_req_o, bus_gnt_o, core_rst_no});
    end
    bus_req_i = 1'b0;
    iccm_gnt_i = 1'b0;
    tick();
    tests++;
    if (core_rst_no !== 1'b0) begin fails++; $display("FAIL core_held: got %b want 0", core_rst_no); end
  endtask

  task automatic test_normal_load();
    do_reset();
    tick();
    iccm_gnt_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ldr_done_i = (i == 7);
      push_word(AW'(i), 32'h1000_0000 + i, 1'b1);
    end
    ldr_wvalid_i = 1'b0;
    tick();
    tick();
    tests++;
    if ({boot_done_o, core_rst_no} !== 2'b00) begin
      fails++; $display("FAIL boot_done_early: got done/rst_n=%b want 00", {boot_done_o, core_rst_no});
    end
    tick();
    tests++;
    if ({boot_done_o, core_rst_no, timeout_o, ovf_err_o} !== 4'b1100) begin
      fails++; $display("FAIL boot_done_late: got done/rst_n/to/ovf=%b want 1100",
                        {boot_done_o, core_rst_no, timeout_o, ovf_err_o});
    end
    tests++;
    if (word_cnt_o !== 14'd8) begin fails++; $display("FAIL load_word_cnt: got %0d want 8", word_cnt_o); end
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL load_writes_missing: got %0d left want 0", exp_q.size()); end
    ldr_done_i = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    tick();
    iccm_gnt_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push_word(AW'(i), 32'h2000_0000 + i, i < 4);
      if (i == 3) begin
        tests++;
        if (ovf_err_o !== 1'b0) begin fails++; $display("FAIL ovf_early: got %b want 0", ovf_err_o); end
      end
      if (i == 4) begin
        tests++;
        if (ovf_err_o !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b want 1", ovf_err_o); end
      end
    end
    ldr_wvalid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({iccm_req_o, iccm_addr_o, iccm_wdata_o} !== {1'b1, 13'h0000, 32'h2000_0000}) begin
        fails++; $display("FAIL stall_stable: got req=%b addr=%h data=%h want 1/0000/20000000",
                          iccm_req_o, iccm_addr_o, iccm_wdata_o);
      end
      tick();
    end
    iccm_gnt_i = 1'b1;
    repeat (6) tick();
    tests++;
    if (word_cnt_o !== 14'd4) begin fails++; $display("FAIL ovf_word_cnt: got %0d want 4", word_cnt_o); end
    tests++;
    if (exp_q.size() != 0 || ovf_err_o !== 1'b1) begin
      fails++; $display("FAIL ovf_drain: got left=%0d ovf=%b want 0/1", exp_q.size(), ovf_err_o);
    end
    iccm_gnt_i = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    tick();
    iccm_gnt_i = 1'b1;
    push_word(13'h0010, 32'h3000_0000, 1'b1);
    push_word(13'h0011, 32'h3000_0001, 1'b1);
    ldr_wvalid_i = 1'b0;
    repeat (14) tick();
    tests++;
    if (timeout_o !== 1'b0) begin fails++; $display("FAIL timeout_early: got %b want 0", timeout_o); end
    repeat (3) tick();
    tests++;
    if (timeout_o !== 1'b1) begin fails++; $display("FAIL timeout_set: got %b want 1", timeout_o); end
    repeat (4) tick();
    tests++;
    if ({boot_done_o, core_rst_no, word_cnt_o} !== {2'b11, 14'd2}) begin
      fails++; $display("FAIL timeout_release: got done=%b rst_n=%b cnt=%0d want 1/1/2",
                        boot_done_o, core_rst_no, word_cnt_o);
    end
  endtask

  task automatic test_handover();
    iccm_gnt_i   = 1'b1;
    bus_req_i    = 1'b1;
    bus_addr_i   = 13'h00AA;
    bus_wdata_i  = 32'hDEAD_BEEF;
    ldr_waddr_i  = 13'h0055;
    ldr_wdata_i  = 32'h5555_5555;
    ldr_wvalid_i = 1'b1;
    exp_q.push_back({13'h00AA, 32'hDEAD_BEEF});
    #1;
    tests++;
    if ({iccm_req_o, bus_gnt_o, iccm_addr_o, iccm_wdata_o} !== {2'b11, 13'h00AA, 32'hDEAD_BEEF}) begin
      fails++; $display("FAIL handover_mux: got req=%b gnt=%b addr=%h data=%h want 1/1/00aa/deadbeef",
                        iccm_req_o, bus_gnt_o, iccm_addr_o, iccm_wdata_o);
    end
    tick();
    bus_req_i = 1'b0;
    ldr_wvalid_i = 1'b0;
    tick();
    tick();
    tests++;
    if (word_cnt_o !== 14'd2 || exp_q.size() != 0 || iccm_req_o !== 1'b0) begin
      fails++; $display("FAIL handover_loader_ignored: got cnt=%0d left=%0d req=%b want 2/0/0",
                        word_cnt_o, exp_q.size(), iccm_req_o);
    end
    iccm_gnt_i = 1'b0;
  endtask

  task automatic test_midload_reset();
    do_reset();
    tick();
    iccm_gnt_i = 1'b0;
    push_word(13'h0001, 32'h4000_0001, 1'b1);
    push_word(13'h0002, 32'h4000_0002, 1'b1);
    ldr_wvalid_i = 1'b0;
    tests++;
    if (iccm_req_o !== 1'b1) begin fails++; $display("FAIL midload_pending: got %b want 1", iccm_req_o); end
    #3;
    csb_rst = 1'b0;
    #1;
    tests++;
    if (outs !== 65'd0) begin fails++; $display("FAIL midload_reset_outputs: got %h want 0", outs); end
    exp_q.delete();
    iccm_gnt_i = 1'b1;
    tick();
    tick();
    csb_rst = 1'b1;
    tick();
    tests++;
    if (outs !== 65'd0) begin fails++; $display("FAIL midload_fresh_idle: got %h want 0", outs); end
    ldr_done_i = 1'b0;
    push_word(13'h0020, 32'h5000_0000, 1'b1);
    ldr_done_i = 1'b1;
    push_word(13'h0021, 32'h5000_0001, 1'b1);
    ldr_wvalid_i = 1'b0;
    repeat (4) tick();
    tests++;
    if ({boot_done_o, core_rst_no, word_cnt_o} !== {2'b11, 14'd2} || exp_q.size() != 0) begin
      fails++; $display("FAIL midload_fresh_load: got done=%b rst_n=%b cnt=%0d left=%0d want 1/1/2/0",
                        boot_done_o, core_rst_no, word_cnt_o, exp_q.size());
    end
    ldr_done_i = 1'b0;
    iccm_gnt_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal_load();
    test_overflow();
    test_timeout();
    test_handover();
    test_midload_reset();
    tick();
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL final_queue: got %0d left want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
